// File: rtl/knight_rider_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : knight_rider_gen_if
// Description : Control/status bundle of the knight_rider_gen LED scanner.
//               master = controller driving run/mode/divider,
//               slave  = scanner producing pattern and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface knight_rider_gen_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 22
);
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] dataOut;
    logic             dir;
    logic             step;
    logic             at_end;

    modport master (output en, mode, div, input dataOut, dir, step, at_end);
    modport slave  (input en, mode, div, output dataOut, dir, step, at_end);
endinterface
`default_nettype wire

// File: rtl/knight_rider_gen.sv
`default_nettype none
// ============================================================================
// Module      : knight_rider_gen
// Description : Parametrised bouncing LED scanner (SCAN/MIRROR/FILL/BLINK)
//               advanced by a programmable prescaler.
//               Optional macro KNIGHT_RIDER_TAIL_EN: SCAN also lights the
//               position vacated by the last tick.
// Revision    : 1.0 - initial release
// ============================================================================
module knight_rider_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 22
) (
    input  logic               clk,
    input  logic               rst,   // asynchronous, active-low
    knight_rider_gen_if.slave  bus
);

    localparam int POS_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MODE_SCAN   = 2'd0,
        MODE_MIRROR = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    logic [DIV_W-1:0] cnt_q;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             end_d;
    mode_e            mode_q, mode_in;
    logic [WIDTH-1:0] data_q, pat_d, tail_mask;
    logic             step_q, at_end_q;
    logic [DIV_W-1:0] div_m1;
    logic             tick, mode_chg;
    logic [POS_W-1:0] max_pos;

    // LED image for a given mode and position (without tail)
    function automatic logic [WIDTH-1:0] pattern(input mode_e m, input logic [POS_W-1:0] p);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (m)
                MODE_SCAN:   v[i] = (POS_W'(i) == p);
                MODE_MIRROR: v[i] = (POS_W'(i) == p) || (POS_W'(WIDTH - 1 - i) == p);
                MODE_FILL:   v[i] = (POS_W'(i) <= p);
                default:     v[i] = p[0];
            endcase
        end
        return v;
    endfunction

    // Prescaler compare, bounce arithmetic and next pattern
    always_comb begin
        mode_in  = mode_e'(bus.mode);
        mode_chg = (mode_in != mode_q);
        // div of zero behaves as one; >= lets a lowered divider tick at once
        div_m1   = (bus.div == '0) ? '0 : bus.div - DIV_W'(1);
        tick     = bus.en && (cnt_q >= div_m1);
        max_pos  = (mode_q == MODE_MIRROR) ? POS_W'(WIDTH / 2 - 1) : POS_W'(WIDTH - 1);
        pos_d    = pos_q;
        dir_d    = dir_q;
        end_d    = 1'b0;
        if (mode_q == MODE_BLINK) begin
            pos_d = (pos_q == '0) ? POS_W'(1) : '0;
            dir_d = 1'b0;
        end else if (!dir_q) begin
            if (pos_q == max_pos) begin
                pos_d = max_pos - POS_W'(1);
                dir_d = 1'b1;
                end_d = 1'b1;
            end else begin
                pos_d = pos_q + POS_W'(1);
            end
        end else begin
            if (pos_q == '0) begin
                pos_d = POS_W'(1);
                dir_d = 1'b0;
                end_d = 1'b1;
            end else begin
                pos_d = pos_q - POS_W'(1);
            end
        end
`ifdef KNIGHT_RIDER_TAIL_EN
        // The tail is the position being vacated on this tick
        tail_mask = (mode_q == MODE_SCAN) ? (WIDTH'(1) << pos_q) : '0;
`else
        tail_mask = '0;
`endif
        pat_d = pattern(mode_q, pos_d) | tail_mask;
    end

    // Scanner state: mode reload has priority over a tick; en=0 freezes all
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= MODE_SCAN;
            cnt_q    <= '0;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            at_end_q <= 1'b0;
            data_q   <= WIDTH'(1);
        end else if (mode_chg) begin
            mode_q   <= mode_in;
            cnt_q    <= '0;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            at_end_q <= 1'b0;
            data_q   <= pattern(mode_in, '0);
        end else if (bus.en) begin
            step_q   <= tick;
            at_end_q <= tick && end_d;
            if (tick) begin
                cnt_q  <= '0;
                pos_q  <= pos_d;
                dir_q  <= dir_d;
                data_q <= pat_d;
            end else begin
                cnt_q  <= cnt_q + DIV_W'(1);
            end
        end else begin
            step_q   <= 1'b0;
            at_end_q <= 1'b0;
        end
    end

    assign bus.dataOut = data_q;
    assign bus.dir     = dir_q;
    assign bus.step    = step_q;
    assign bus.at_end  = at_end_q;

endmodule
`default_nettype wire

// File: tb/tb_knight_rider_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_knight_rider_gen
// Description : Randomised self-checking bench for knight_rider_gen, compared
//               against a step-count / triangle-wave reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_knight_rider_gen;

    localparam int W  = 8;
    localparam int DW = 22;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    knight_rider_gen_if #(.WIDTH(W), .DIV_W(DW)) bus ();
    knight_rider_gen #(.WIDTH(W), .DIV_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: mode, prescale count, ticks since last mode load
    int   m_mode, m_cnt, m_n;
    logic m_step, m_end;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int max_pos(input int md);
        return (md == 1) ? W / 2 - 1 : W - 1;
    endfunction

    function automatic int period(input int md);
        return 2 * max_pos(md);
    endfunction

    // Position as a triangle wave of the tick count
    function automatic int pos_of(input int md, input int n);
        int ph;
        if (md == 3) return n % 2;
        ph = n % period(md);
        return (ph <= max_pos(md)) ? ph : period(md) - ph;
    endfunction

    // Direction flips only when leaving an end, so an arrival at 0 still reads 1
    function automatic logic dir_of(input int md, input int n);
        int ph;
        if (md == 3) return 1'b0;
        ph = n % period(md);
        return (ph > max_pos(md)) || (ph == 0 && n > 0);
    endfunction

    function automatic logic [W-1:0] pat(input int md, input int n);
        logic [W-1:0] v;
        int p;
        v = '0;
        p = pos_of(md, n);
        case (md)
            0: begin
                v[p] = 1'b1;
`ifdef KNIGHT_RIDER_TAIL_EN
                if (n > 0) v[pos_of(0, n - 1)] = 1'b1;
`endif
            end
            1: begin
                v[p] = 1'b1;
                v[W - 1 - p] = 1'b1;
            end
            2: for (int i = 0; i <= p; i++) v[i] = 1'b1;
            default: v = (p != 0) ? '1 : '0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_n = 0; m_step = 1'b0; m_end = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_clock();
        int dv, ph;
        if (int'(bus.mode) != m_mode) begin
            m_mode = int'(bus.mode); m_cnt = 0; m_n = 0; m_step = 1'b0; m_end = 1'b0;
        end else if (bus.en) begin
            dv = (bus.div == '0) ? 1 : int'(bus.div);
            if (m_cnt >= dv - 1) begin
                m_cnt  = 0;
                m_n++;
                m_step = 1'b1;
                ph     = m_n % period(m_mode);
                m_end  = (m_mode != 3) && ((ph == max_pos(m_mode) + 1) || (ph == 1 && m_n > 1));
            end else begin
                m_cnt++;
                m_step = 1'b0;
                m_end  = 1'b0;
            end
        end else begin
            m_step = 1'b0;
            m_end  = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("dataOut", 32'(bus.dataOut), 32'(pat(m_mode, m_n)));
        check("dir",     32'(bus.dir),     32'(dir_of(m_mode, m_n)));
        check("step",    32'(bus.step),    32'(m_step));
        check("at_end",  32'(bus.at_end),  32'(m_end));
    endtask

    initial begin
        rst      = 1'b0;
        bus.en   = 1'b1;
        bus.mode = 2'd0;
        bus.div  = DW'(3);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            // Directed openings, then random traffic
            if (i >= 20 && i < 30)  bus.en = 1'b0;
            else if (i == 30)       bus.en = 1'b1;
            else if (i == 60)  begin bus.mode = 2'd1; bus.div = DW'(1); end
            else if (i == 100) begin bus.mode = 2'd2; bus.div = DW'(2); end
            else if (i == 160) begin bus.mode = 2'd3; bus.div = DW'(0); end
            else if (i == 200) begin bus.mode = 2'd0; bus.div = DW'(1); end
            else if (i >= 240) begin
                if ($urandom_range(0, 149) == 0) bus.mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15)  == 0) bus.en   = ~bus.en;
                if ($urandom_range(0, 59)  == 0) bus.div  = DW'($urandom_range(0, 6));
            end

            if (i == 2500) begin
                // Asynchronous reset between edges must take effect at once
                #2 rst = 1'b0;
                #1;
                model_reset();
                compare_all();
                @(posedge clk);
                #1;
                compare_all();
                rst = 1'b1;
            end else begin
                @(posedge clk);
                model_clock();
                #1;
                compare_all();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
